// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
// Address width is derived from the register count so all files agree on it.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    function automatic int addr_width(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    localparam int AW_DEF = addr_width(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] data_word_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue sets a bit, writeback clears it.
// Also keeps a registered OR of all busy bits for pipeline drain detection.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 2,
    localparam int AW   = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    output logic [NREGS-1:0]  busy,
    output logic              busy_any
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_next_s;
    logic             busy_any_r;

    // Next busy vector: writebacks clear first so a same-cycle alloc wins
    always_comb begin
        busy_next_s = busy_r;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                busy_next_s[wr_addr[j*AW +: AW]] = 1'b0;
            end else begin
                busy_next_s = busy_next_s;
            end
        end
        if (alloc_en && (alloc_addr != AW'(ZERO_REG))) begin
            busy_next_s[alloc_addr] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
        busy_next_s[ZERO_REG] = 1'b0;
    end

    // Busy state and drain flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r     <= {NREGS{1'b0}};
            busy_any_r <= 1'b0;
        end else begin
            busy_r     <= busy_next_s;
            busy_any_r <= |busy_next_s;
        end
    end

    assign busy     = busy_r;
    assign busy_any = busy_any_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard.
// Register 0 reads as zero; on write conflicts the highest-index port wins.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic                busy_any
);

    logic [XLEN-1:0]     regs_r [NREGS];
    logic [NREGS-1:0]    busy_s;
    logic [NRD*XLEN-1:0] rd_data_s;
    logic [NRD-1:0]      rd_busy_s;
    logic [AW-1:0]       addr_s;
    logic [XLEN-1:0]     word_s;
    logic                hit_s;

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy       (busy_s),
        .busy_any   (busy_any)
    );

    // Storage update; later loop iterations override earlier ones on conflict
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= {XLEN{1'b0}};
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
                    regs_r[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Read ports: stored value, optionally overridden by a same-cycle write
    always_comb begin
        rd_data_s = {(NRD*XLEN){1'b0}};
        rd_busy_s = {NRD{1'b0}};
        addr_s    = {AW{1'b0}};
        word_s    = {XLEN{1'b0}};
        hit_s     = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            addr_s = rd_addr[i*AW +: AW];
            word_s = regs_r[addr_s];
            hit_s  = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if ((BYPASS != 0) && wr_en[j] && (wr_addr[j*AW +: AW] == addr_s)) begin
                    word_s = wr_data[j*XLEN +: XLEN];
                    hit_s  = 1'b1;
                end else begin
                    word_s = word_s;
                end
            end
            if (reset || (addr_s == AW'(ZERO_REG))) begin
                rd_data_s[i*XLEN +: XLEN] = {XLEN{1'b0}};
                rd_busy_s[i]              = 1'b0;
            end else begin
                rd_data_s[i*XLEN +: XLEN] = word_s;
                rd_busy_s[i]              = busy_s[addr_s] & ~hit_s;
            end
        end
    end

    assign rd_data = rd_data_s;
    assign rd_busy = rd_busy_s;

endmodule
